// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the uDLX memory-access stage.
// Imported by the stage top and its timeout counter.
package dlx_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic WB_SEL_ALU = 1'b0;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/memory_access_pipe_timeout.sv
// Access watchdog: counts stalled ACCESS cycles and flags the last one.
// tc is combinational so the abort lands on the very next edge.
module mem_timeout_counter
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/memory_access_pipe.sv
// uDLX EX/MEM consumer: data-memory req/ack access with upstream stall,
// registered MEM/WB bundle and forwarded PC redirect.
module memory_access_pipe
  import dlx_mem_pkg::*;
#(
  parameter int PC_WIDTH       = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      select_new_pc_in,
  input  logic [PC_WIDTH-1:0]       new_pc_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      stall_out,
  output logic                      wb_reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic                      select_new_pc_out,
  output logic [PC_WIDTH-1:0]       new_pc_out,
  output logic                      mem_error_out
);

  mem_state_e state_q;
  mem_state_e state_d;

  logic                      hold_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] hold_addr_q;
  logic                      hold_sel_q;
  logic [DATA_WIDTH-1:0]     hold_alu_q;

  logic mem_op;
  logic both_op;
  logic ack_v;
  logic start;
  logic wait_en;
  logic timeout;

  assign mem_op  = mem_data_rd_en_in | mem_data_wr_en_in;
  assign both_op = mem_data_rd_en_in & mem_data_wr_en_in;
  // ack only counts while a request is actually out
  assign ack_v   = dmem_ack & dmem_req;
  assign start   = (state_q == IDLE) & mem_op;
  assign wait_en = (state_q == ACCESS) & ~ack_v;

  assign stall_out = (state_q == ACCESS);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .en (wait_en),
    .tc (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (ack_v || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_wdata         <= '0;
      wb_reg_wr_en_out   <= 1'b0;
      wb_reg_wr_addr_out <= '0;
      wb_data_out        <= '0;
      select_new_pc_out  <= 1'b0;
      new_pc_out         <= '0;
      mem_error_out      <= 1'b0;
      hold_wr_en_q       <= 1'b0;
      hold_addr_q        <= '0;
      hold_sel_q         <= WB_SEL_ALU;
      hold_alu_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!mem_op) begin
            wb_reg_wr_en_out   <= reg_wr_en_in;
            wb_reg_wr_addr_out <= reg_wr_addr_in;
            wb_data_out        <= alu_data_in;
            select_new_pc_out  <= select_new_pc_in;
            new_pc_out         <= new_pc_in;
          end else begin
            // a conflicting rd+wr is carried out as a store
            dmem_req          <= 1'b1;
            dmem_we           <= mem_data_wr_en_in;
            dmem_addr         <= alu_data_in[MEM_ADDR_WIDTH-1:0];
            dmem_wdata        <= mem_data_in;
            hold_wr_en_q      <= reg_wr_en_in;
            hold_addr_q       <= reg_wr_addr_in;
            hold_sel_q        <= write_back_mux_sel_in;
            hold_alu_q        <= alu_data_in;
            wb_reg_wr_en_out  <= 1'b0;
            select_new_pc_out <= 1'b0;
            if (both_op) begin
              mem_error_out <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (ack_v) begin
            dmem_req           <= 1'b0;
            wb_reg_wr_en_out   <= hold_wr_en_q;
            wb_reg_wr_addr_out <= hold_addr_q;
            wb_data_out        <= (hold_sel_q == WB_SEL_MEM) ?
                                  dmem_rdata : hold_alu_q;
          end else if (timeout) begin
            dmem_req         <= 1'b0;
            wb_reg_wr_en_out <= 1'b0;
            mem_error_out    <= 1'b1;
          end
        end
        default: begin
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_pipe.sv
// Scoreboard bench for memory_access_pipe: directed ops push expected
// write-backs, a negedge monitor pops and compares them.
module tb_memory_access_pipe;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] mem_data;
  logic [31:0] alu_data;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic        mux_sel;
  logic        sel_pc;
  logic [19:0] new_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [19:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sel_pc_o;
  logic [19:0] new_pc_o;
  logic        mem_err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t got_e;

  int n_cmp = 0;
  int n_err = 0;

  memory_access_pipe #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_data_rd_en_in    (rd_en),
    .mem_data_wr_en_in    (wr_en),
    .mem_data_in          (mem_data),
    .alu_data_in          (alu_data),
    .reg_wr_en_in         (reg_wr_en),
    .reg_wr_addr_in       (reg_wr_addr),
    .write_back_mux_sel_in(mux_sel),
    .select_new_pc_in     (sel_pc),
    .new_pc_in            (new_pc),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .stall_out            (stall),
    .wb_reg_wr_en_out     (wb_en),
    .wb_reg_wr_addr_out   (wb_addr),
    .wb_data_out          (wb_data),
    .select_new_pc_out    (sel_pc_o),
    .new_pc_out           (new_pc_o),
    .mem_error_out        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic nop();
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    mem_data    = '0;
    alu_data    = '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    mux_sel     = 1'b0;
    sel_pc      = 1'b0;
    new_pc      = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && wb_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got addr %h data %h, want none",
                 wb_addr, wb_data);
      end else begin
        got_e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(got_e.addr));
        chk("wb_data", wb_data, got_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    nop();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_wb_en", 32'(wb_en), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_sel_pc", 32'(sel_pc_o), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    rst = 1'b0;

    // ALU op with PC redirect
    @(negedge clk);
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd3;
    alu_data    = 32'h1234;
    sel_pc      = 1'b1;
    new_pc      = 20'h0ABCD;
    exp_q.push_back('{5'd3, 32'h1234});
    @(negedge clk);
    nop();
    chk("alu_stall", 32'(stall), 32'h0);
    chk("alu_sel_pc", 32'(sel_pc_o), 32'h1);
    chk("alu_new_pc", 32'(new_pc_o), 32'h0ABCD);
    @(negedge clk);
    chk("nop_sel_pc", 32'(sel_pc_o), 32'h0);

    // load, ack on the 3rd ACCESS cycle
    rd_en       = 1'b1;
    alu_data    = 32'h40;
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd7;
    mux_sel     = 1'b1;
    exp_q.push_back('{5'd7, 32'hDEADBEEF});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nop();
      chk("ld_stall", 32'(stall), 32'h1);
      chk("ld_req", 32'(dmem_req), 32'h1);
      chk("ld_we", 32'(dmem_we), 32'h0);
      chk("ld_addr", 32'(dmem_addr), 32'h40);
      if (k == 3) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
    end
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    chk("ld_done_stall", 32'(stall), 32'h0);
    chk("ld_done_req", 32'(dmem_req), 32'h0);
    @(negedge clk);
    chk("ld_one_cycle", 32'(wb_en), 32'h0);

    // store, ack in the first ACCESS cycle
    wr_en    = 1'b1;
    alu_data = 32'h10;
    mem_data = 32'hA5A5A5A5;
    @(negedge clk);
    nop();
    chk("st_req", 32'(dmem_req), 32'h1);
    chk("st_we", 32'(dmem_we), 32'h1);
    chk("st_addr", 32'(dmem_addr), 32'h10);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_stall", 32'(stall), 32'h1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("st_done_req", 32'(dmem_req), 32'h0);
    chk("st_done_stall", 32'(stall), 32'h0);
    chk("st_wb_en", 32'(wb_en), 32'h0);
    chk("st_err", 32'(mem_err), 32'h0);

    // store with reg write returns the address value
    wr_en       = 1'b1;
    alu_data    = 32'h20;
    mem_data    = 32'h0BADF00D;
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd9;
    dmem_rdata  = 32'hFFFFFFFF;
    exp_q.push_back('{5'd9, 32'h20});
    @(negedge clk);
    nop();
    chk("stwb_we", 32'(dmem_we), 32'h1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;

    // load that never acks: abort after 4 ACCESS cycles
    rd_en       = 1'b1;
    alu_data    = 32'h80;
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd5;
    mux_sel     = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      nop();
      chk("to_stall", 32'(stall), 32'h1);
      chk("to_req", 32'(dmem_req), 32'h1);
    end
    @(negedge clk);
    chk("to_abort_stall", 32'(stall), 32'h0);
    chk("to_abort_req", 32'(dmem_req), 32'h0);
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_wb_en", 32'(wb_en), 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12121212;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    chk("stray_ack_stall", 32'(stall), 32'h0);
    chk("stray_ack_req", 32'(dmem_req), 32'h0);
    chk("to_err_sticky", 32'(mem_err), 32'h1);

    // reset in the 2nd ACCESS cycle
    rd_en       = 1'b1;
    alu_data    = 32'h44;
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd6;
    mux_sel     = 1'b1;
    @(negedge clk);
    nop();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(dmem_req), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_wb_en", 32'(wb_en), 32'h0);
    chk("arst_wb_addr", 32'(wb_addr), 32'h0);
    chk("arst_wb_data", wb_data, 32'h0);
    chk("arst_err", 32'(mem_err), 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    reg_wr_en   = 1'b1;
    reg_wr_addr = 5'd12;
    alu_data    = 32'h5555AAAA;
    exp_q.push_back('{5'd12, 32'h5555AAAA});
    @(negedge clk);
    nop();
    chk("post_rst_stall", 32'(stall), 32'h0);

    // rd and wr together: store plus error
    rd_en    = 1'b1;
    wr_en    = 1'b1;
    alu_data = 32'h30;
    mem_data = 32'h11223344;
    @(negedge clk);
    nop();
    chk("both_req", 32'(dmem_req), 32'h1);
    chk("both_we", 32'(dmem_we), 32'h1);
    chk("both_wdata", dmem_wdata, 32'h11223344);
    chk("both_err", 32'(mem_err), 32'h1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("both_done_req", 32'(dmem_req), 32'h0);
    chk("both_err_sticky", 32'(mem_err), 32'h1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
